// File: rtl/ex_stage_input_queue.sv
// Decode-to-execute staging FIFO for the operand bundle, with a valid/ready
// handshake on both sides, a redirect flush and a saturating back-pressure counter.
module ex_stage_input_queue #(
    parameter int XLEN    = 32,
    parameter int CTRL_W  = 16,
    parameter int DEPTH   = 4,
    parameter int STALL_W = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [XLEN-1:0]            in_data1,
    input  logic [XLEN-1:0]            in_data2,
    input  logic [XLEN-1:0]            in_imm,
    input  logic [CTRL_W-1:0]          in_control,
    input  logic                       in_compflg,
    input  logic [XLEN-1:0]            in_pc,
    input  logic                       flush,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [XLEN-1:0]            out_data1,
    output logic [XLEN-1:0]            out_data2,
    output logic [XLEN-1:0]            out_imm,
    output logic [CTRL_W-1:0]          out_control,
    output logic                       out_compflg,
    output logic [XLEN-1:0]            out_pc,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [STALL_W-1:0]         stall_cycles
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    typedef struct packed {
        logic [XLEN-1:0]   data1;
        logic [XLEN-1:0]   data2;
        logic [XLEN-1:0]   imm;
        logic [CTRL_W-1:0] control;
        logic              compflg;
        logic [XLEN-1:0]   pc;
    } entry_t;

    // Handshake: a bundle moves on a rising edge only when valid and ready are
    // both high on that side and flush is low; flush overrides both transfers.
    entry_t             mem_q [DEPTH];
    entry_t             in_entry;
    entry_t             head_entry;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [STALL_W-1:0] stall_q, stall_d;
    logic               full;
    logic               empty;
    logic               push;
    logic               pop;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);

    // in_ready depends on registered occupancy only, never on out_ready.
    assign in_ready  = rst_n & ~full;
    assign out_valid = ~empty;

    assign push = in_valid & in_ready & ~flush;
    assign pop  = out_valid & out_ready & ~flush;

    assign in_entry = '{data1:   in_data1,
                        data2:   in_data2,
                        imm:     in_imm,
                        control: in_control,
                        compflg: in_compflg,
                        pc:      in_pc};

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        stall_d  = stall_q;
        if (out_valid && !out_ready && (stall_q != '1)) begin
            stall_d = stall_q + STALL_W'(1);
        end
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            stall_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            stall_q  <= stall_d;
        end
    end

    // Payload storage carries no reset; occupancy alone says what is live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_entry;
        end
    end

    assign head_entry   = mem_q[rd_ptr_q];
    assign out_data1    = head_entry.data1;
    assign out_data2    = head_entry.data2;
    assign out_imm      = head_entry.imm;
    assign out_control  = head_entry.control;
    assign out_compflg  = head_entry.compflg;
    assign out_pc       = head_entry.pc;
    assign count        = count_q;
    assign stall_cycles = stall_q;

endmodule
